// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared definitions for the serial BCD adder.
//   bcd_state_e   : controller states (IDLE, RUN, DONE)
//   DIGIT_W       : bits per BCD digit
//   BCD_MAX_DIGIT : largest legal BCD digit value
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder -- combinational single-digit BCD adder with decimal correction.
// Ports:
//   a, b  : 4-bit digit operands (a digit above 9 is not trapped here)
//   cin   : carry in
//   s     : 4-bit corrected digit result
//   cout  : decimal carry out (binary sum exceeded 9)
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);

  logic [DIGIT_W:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    cout = (raw > {1'b0, BCD_MAX_DIGIT});
    // Subtracting 10 and adding 6 agree modulo 16, so the low nibble plus 6 is the corrected digit.
    s    = cout ? (raw[DIGIT_W-1:0] + DIGIT_W'(6)) : raw[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder -- digit-serial BCD add/subtract, one digit per clock, LSD first.
// Subtraction is A + nines-complement(B) + 1; the final carry is inverted into a borrow.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operation handshake (A, B, sub captured on acceptance)
//   A, B                  : packed BCD operands, digit 0 in bits [3:0]
//   sub                   : 0 = A+B, 1 = A-B
//   out_valid / out_ready : result handshake; result held until out_ready
//   out_sum               : packed BCD result
//   out_carry             : carry-out on add, borrow (A<B) on sub
//   out_err               : an operand digit exceeded 9
// Optional feature: define BCD_INVALID_CHECK_EN to trap illegal operand digits at capture;
// without it out_err is constant 0 and illegal digits pass through the digit arithmetic.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_sum,
  output logic                  out_carry,
  output logic                  out_err
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_state_e         state, state_nx;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               sub_q, carry_q, out_valid_q;
  logic [IDX_W-1:0]   idx;
  logic               accept, in_bad, err_q;

  logic [DIGIT_W-1:0] dig_b, dig_s;
  logic               dig_cout;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Operands shift right each RUN cycle, so the current digit is always the low nibble.
  assign dig_b = sub_q ? (BCD_MAX_DIGIT - b_q[DIGIT_W-1:0]) : b_q[DIGIT_W-1:0];

  bcd_digit_adder u_digit (
    .a    (a_q[DIGIT_W-1:0]),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

`ifdef BCD_INVALID_CHECK_EN
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((A[i*DIGIT_W +: DIGIT_W] > BCD_MAX_DIGIT) || (B[i*DIGIT_W +: DIGIT_W] > BCD_MAX_DIGIT))
        in_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= in_bad;
  end

  assign out_err = out_valid_q & err_q;
`else
  assign in_bad  = 1'b0;
  assign err_q   = 1'b0;
  assign out_err = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = in_bad ? DONE : RUN;
      RUN:     if (idx == LAST_IDX) state_nx = DONE;
      DONE:    if (out_valid_q && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath is reset too (it is only a few registers), so an aborted operation leaves nothing behind.
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        sub_q   <= sub;
        carry_q <= sub;   // +1 that completes the tens complement on subtract
        sum_q   <= '0;
        idx     <= '0;
      end else if (state == RUN) begin
        a_q     <= a_q >> DIGIT_W;
        b_q     <= b_q >> DIGIT_W;
        sum_q   <= (sum_q >> DIGIT_W) | (W'(dig_s) << (W - DIGIT_W));
        carry_q <= dig_cout;
        idx     <= idx + 1'b1;
      end

      // The first DONE cycle publishes the result; out_valid then holds until consumed.
      if (state == DONE && !out_valid_q)
        out_valid_q <= 1'b1;
      else if (out_valid_q && out_ready)
        out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = (out_valid_q && !err_q) ? sum_q : '0;
  assign out_carry = out_valid_q & ~err_q & (carry_q ^ sub_q);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder -- self-checking bench for bcd_serial_adder (DIGITS=4).
// Expected results come from integer arithmetic on the decimal values of the operands.
// Honours BCD_INVALID_CHECK_EN when deciding what an illegal operand should produce.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MODV   = 10000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check({tag, " ready_wait"}, 64'(in_ready), 64'(1));
  endtask

  // One full operation: issue, measure latency, compare result, consume.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit legal);
    int           ai, bi, r, lat, exp_lat;
    logic [W-1:0] exp_sum;
    logic         exp_c, exp_e;
    ai = bcd_to_int(a);
    bi = bcd_to_int(b);
    if (!s) begin
      r     = ai + bi;
      exp_c = (r >= MODV);
      r     = r % MODV;
    end else begin
      exp_c = (ai < bi);
      r     = (ai - bi + MODV) % MODV;
    end
    exp_sum = int_to_bcd(r);
    exp_e   = 1'b0;
    exp_lat = DIGITS + 1;
`ifdef BCD_INVALID_CHECK_EN
    if (!legal) begin
      exp_sum = '0;
      exp_c   = 1'b0;
      exp_e   = 1'b1;
      exp_lat = 1;
    end
`endif
    wait_ready(tag);
    A = a; B = b; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); sub = ~s;   // captured values must not follow the bus
    check({tag, " busy"}, 64'(in_ready), 64'(0));
    lat = 0;
    while (!out_valid && lat < 4 * DIGITS + 8) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    if (legal || exp_e) begin
      check({tag, " sum"}, 64'(out_sum), 64'(exp_sum));
      check({tag, " carry"}, 64'(out_carry), 64'(exp_c));
    end
    check({tag, " err"}, 64'(out_err), 64'(exp_e));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " consumed"}, 64'(out_valid), 64'(0));
    check({tag, " idle"}, 64'(in_ready), 64'(1));
    check({tag, " zero_sum"}, 64'(out_sum), 64'(0));
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_c;
    int           n;
    bit           seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; sub = 1'b0;
    tick();
    tick();
    check("reset in_ready",  64'(in_ready),  64'(1));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset out_sum",   64'(out_sum),   64'(0));
    check("reset out_carry", 64'(out_carry), 64'(0));
    check("reset out_err",   64'(out_err),   64'(0));
    rst = 1'b0;
    tick();

    // Directed arithmetic cases, including wrap and borrow boundaries.
    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b1);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b1);
    run_op("sub_0100_0001", 16'h0100, 16'h0001, 1'b1, 1'b1);
    run_op("sub_0001_0002", 16'h0001, 16'h0002, 1'b1, 1'b1);
    run_op("add_9999_9999", 16'h9999, 16'h9999, 1'b0, 1'b1);
    run_op("sub_equal",     16'h4321, 16'h4321, 1'b1, 1'b1);

    // Illegal digit in A.
    run_op("illegal_12A4",  16'h12A4, 16'h0001, 1'b0, 1'b0);

    // Result held for 10 cycles with out_ready low; a new request meanwhile is ignored.
    wait_ready("hold");
    A = 16'h2468; B = 16'h1357; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check("hold valid", 64'(out_valid), 64'(1));
    held_sum = out_sum;
    held_c   = out_carry;
    check("hold first_sum", 64'(held_sum), 64'(16'h3825));
    A = 16'h1111; B = 16'h1111; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold sum",      64'(out_sum),   64'(16'h3825));
      check("hold carry",    64'(out_carry), 64'(0));
      check("hold in_ready", 64'(in_ready),  64'(0));
      check("hold out_valid", 64'(out_valid), 64'(1));
      if (i == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold released", 64'(out_valid), 64'(0));
    check("hold to_idle",  64'(in_ready),  64'(1));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("hold no_ghost_op", 64'(seen), 64'(0));

    // Reset during the third RUN cycle aborts the operation.
    A = 16'h0123; B = 16'h0456; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort in_ready",  64'(in_ready),  64'(1));
    check("abort out_valid", 64'(out_valid), 64'(0));
    check("abort out_sum",   64'(out_sum),   64'(0));
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort no_result", 64'(seen), 64'(0));
    run_op("add_0005_0005", 16'h0005, 16'h0005, 1'b0, 1'b1);

    // Randomized legal operations against the integer model.
    for (int k = 0; k < 24; k++) begin
      run_op($sformatf("rand%0d", k), rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Randomized operand with one illegal digit.
    begin
      logic [W-1:0] bad;
      bad = rand_bcd();
      bad[4 * $urandom_range(0, DIGITS - 1) +: 4] = 4'($urandom_range(10, 15));
      run_op("rand_illegal", rand_bcd(), bad, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
